dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter for the single-port data memory in the MIPS32 SoC. It shares the data memory between the CPU load/store path (port 0) and a debug/loader master (port 1). The CPU has fixed priority, with a starvation limit that guarantees the debug master forward progress, and an optional debug lock for burst access. It drives a `cpu_stall` line that freezes the PC and register-file write while the CPU is denied.

## Interface
Parameters:
- `ADDR_W`, 8: word address width; matches the data-memory address.
- `DATA_W`, 32: data width.
- `MAX_WAIT`, 4: number of consecutive denied cycles on port 1 that forces a port-1 grant. Legal range is 1–15.
- `STAT_W`, 16: width of the stall statistics counter.

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `m0_req` in 1: CPU access request; held for the whole access.
- `m0_we` in 1: CPU access is a write (1) or a read (0).
- `m0_addr` in ADDR_W: CPU word address.
- `m0_wdata` in DATA_W: CPU write data.
- `m0_gnt` out 1: CPU access performed this cycle.
- `m0_rdata` out DATA_W: read data; valid when `m0_gnt & ~m0_we`.
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata` in: debug master request fields, same meaning as the port-0 fields.
- `m1_lock` in 1: request to keep ownership after this grant.
- `m1_gnt` out 1: debug access performed this cycle.
- `m1_rdata` out DATA_W: debug read data.
- `mem_addr` out ADDR_W: address to the data memory.
- `mem_wdata` out DATA_W: write data to the data memory.
- `mem_write` out 1: data-memory write enable.
- `mem_read` out 1: data-memory read enable.
- `mem_rdata` in DATA_W: combinational read data from the data memory.
- `cpu_stall` out 1: equals `m0_req & ~m0_gnt`.
- `stall_cnt` out STAT_W: saturating count of cycles with `cpu_stall` high.

## Operation
- One access is performed per cycle.
- The grant is combinational from the current requests and the registered state:
  - owner state: IDLE or LOCK1;
  - `wait_cnt` (4 bit).
- Grant rule in IDLE:
  - `m1_gnt` when `m1_req & (~m0_req | wait_cnt == MAX_WAIT)`;
  - otherwise `m0_gnt = m0_req`.
- Grant rule in LOCK1:
  - `m1_gnt = m1_req`;
  - `m0_gnt = 0`.
- Exactly one grant or none is ever asserted; a grant never asserts without its request.
- Memory mux, driven from the granted port:
  - `mem_addr` and `mem_wdata` come from the granted port;
  - `mem_write = gnt & we`;
  - `mem_read = gnt & ~we`.
- With no grant, `mem_write = mem_read = 0` and `mem_addr` and `mem_wdata` are 0.
- `m0_rdata` and `m1_rdata` both carry `mem_rdata`. Each is meaningful only with its own grant.
- `wait_cnt` update:
  - cleared on `m1_gnt` or when `~m1_req`;
  - otherwise incremented, saturating at MAX_WAIT.
- FSM transitions:
  - IDLE → LOCK1 when `m1_gnt & m1_lock`.
  - LOCK1 → IDLE when `~m1_req | ~m1_lock` is sampled at the clock edge.
  - The cycle in which the lock is dropped is still owned by port 1.
- `stall_cnt` increments when `cpu_stall` is high and holds at all-ones.
- Reset:
  - FSM → IDLE, `wait_cnt = 0`, `stall_cnt = 0`;
  - while `rst` is high, both grants, `mem_write`, `mem_read` and `cpu_stall` are forced to 0;
  - reset during LOCK1 abandons the burst; any access in the reset cycle is not performed.

## Timing
- Zero-cycle grant latency: request and grant occur in the same cycle.
- Read data is valid in the grant cycle, since the data memory reads combinationally.
- A write commits on the rising edge that ends the grant cycle.
- Requesters hold `req` and the request fields stable until `gnt`. Changing them while denied is allowed and takes effect immediately.
- Under a continuous `m0_req`, a continuously requesting port 1 is granted on the (MAX_WAIT+1)-th cycle of its request.
  - After that grant, the CPU is served again on the following cycle unless a lock was taken.
- Simultaneous requests with `wait_cnt < MAX_WAIT`: port 0 wins.
- The `stall_cnt` update is registered, so it lags `cpu_stall` by one cycle.

## Structure
- Package `dmem_arb_pkg`:
  - state enum `{ARB_IDLE, ARB_LOCK1}`;
  - port index constants `ARB_CPU = 0`, `ARB_DBG = 1`;
  - default parameter constants.
- One natural sub-module: `arb_starve_counter`, covering `wait_cnt` and the saturating `stall_cnt` logic with generic width and limit, instantiated twice.
- Top level: grant logic, FSM register and memory mux.

## Test plan
- Port 0 only, write 0xDEADBEEF @0x10 then read @0x10 → `m0_gnt` each cycle; read returns 0xDEADBEEF; `cpu_stall` stays 0.
- Both ports request continuously with no lock and MAX_WAIT = 4 → `m1_gnt` on the 5th cycle only; `cpu_stall` is 1 in exactly that cycle; `stall_cnt` = 1 on the next cycle.
- Port 1 burst: 4 writes 0x1..0x4 to @0x20..0x23 with `m1_lock = 1`, CPU requesting throughout → 4 consecutive `m1_gnt`; `m0_gnt` = 0 during the burst; the CPU is granted the cycle after the lock drops.
- Port 1 alone with `m0_req = 0` → granted on its first request cycle; `wait_cnt` stays 0.
- Reset asserted in the 2nd cycle of a locked burst → all grants and `mem_write` are 0 in the reset cycle; FSM is IDLE; the next cycle grants port 0 on simultaneous requests.
- `stall_cnt` forced near saturation (STAT_W = 4) with 20 stall cycles → holds at 0xF.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
//   arb_state_t      - ownership state (normal priority arbitration / debug burst lock)
//   ARB_CPU/ARB_DBG  - grant-vector indices for the CPU and debug ports
//   DEF_*            - default parameter values
package dmem_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_LOCK1 = 1'b1
    } arb_state_t;

    localparam int ARB_CPU = 0;
    localparam int ARB_DBG = 1;

    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_MAX_WAIT = 4;
    localparam int DEF_STAT_W   = 16;

    // Width of the debug-port starvation counter; holds MAX_WAIT up to 15.
    localparam int WAIT_W = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter: saturating up-counter with a synchronous clear.
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear to zero (wins over inc)
//   inc      : count up by one, stopping at LIMIT
//   cnt      : current count
// Used both as the debug-port wait counter and the CPU stall statistic.
module arb_starve_counter
    import dmem_arb_pkg::*;
#(
    parameter int           W     = 4,
    parameter logic [W-1:0] LIMIT = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != LIMIT))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU (port 0)
// and the debug/loader master (port 1).
//   clk, rst                      : clock, synchronous active-high reset
//   m0_* (req/we/addr/wdata)      : CPU request;   m0_gnt/m0_rdata back
//   m1_* (req/we/addr/wdata/lock) : debug request; m1_gnt/m1_rdata back
//   mem_*                         : data-memory interface (combinational read)
//   cpu_stall                     : CPU requesting but denied this cycle
//   stall_cnt                     : saturating count of stalled cycles
// CPU has fixed priority; a debug request denied MAX_WAIT cycles in a row is
// forced through. A locked debug grant keeps ownership until lock/req drops.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int STAT_W   = DEF_STAT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_stall,
    output logic [STAT_W-1:0] stall_cnt
);

    arb_state_t        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        gnt;
    logic              starved;

    assign starved = (wait_cnt == WAIT_W'(MAX_WAIT));

    // Grants are combinational; reset masks every grant so nothing is
    // performed in a reset cycle.
    always_comb begin
        gnt = '0;
        if (!rst) begin
            if (state == ARB_LOCK1)
                gnt[ARB_DBG] = m1_req;
            else if (m1_req && (!m0_req || starved))
                gnt[ARB_DBG] = 1'b1;
            else
                gnt[ARB_CPU] = m0_req;
        end
    end

    assign m0_gnt    = gnt[ARB_CPU];
    assign m1_gnt    = gnt[ARB_DBG];
    assign cpu_stall = m0_req & ~m0_gnt & ~rst;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        if (m0_gnt) begin
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_write = m0_we;
            mem_read  = ~m0_we;
        end else if (m1_gnt) begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_write = m1_we;
            mem_read  = ~m1_we;
        end
    end

    assign m0_rdata = mem_rdata;
    assign m1_rdata = mem_rdata;

    // The cycle in which lock drops is still a port-1 cycle; ownership
    // returns to normal arbitration on the following edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            case (state)
                ARB_IDLE:  if (m1_gnt && m1_lock)  state <= ARB_LOCK1;
                ARB_LOCK1: if (!m1_req || !m1_lock) state <= ARB_IDLE;
                default:   state <= ARB_IDLE;
            endcase
        end
    end

    // Counts consecutive denied port-1 cycles.
    arb_starve_counter #(
        .W     (WAIT_W),
        .LIMIT (WAIT_W'(MAX_WAIT))
    ) u_wait (
        .clk (clk),
        .rst (rst),
        .clr (m1_gnt | ~m1_req),
        .inc (1'b1),
        .cnt (wait_cnt)
    );

    arb_starve_counter #(
        .W     (STAT_W),
        .LIMIT ({STAT_W{1'b1}})
    ) u_stall (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (cpu_stall),
        .cnt (stall_cnt)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench for dmem_arbiter. The driver
// pushes one hand-computed expectation per cycle; the monitor pops and
// compares on the falling edge. A second instance with STAT_W=4 shares the
// stimulus to exercise stall_cnt saturation.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
    logic [7:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, mem_write, mem_read, cpu_stall;
    logic [31:0] m0_rdata, m1_rdata, mem_wdata, mem_rdata;
    logic [7:0]  mem_addr;
    logic [15:0] stall_cnt;

    logic        s_m0_gnt, s_m1_gnt, s_mem_write, s_mem_read, s_cpu_stall;
    logic [31:0] s_m0_rdata, s_m1_rdata, s_mem_wdata;
    logic [7:0]  s_mem_addr;
    logic [3:0]  s_stall_cnt;

    int checks = 0;
    int errors = 0;
    int stall_m = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_WAIT(4), .STAT_W(16)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_read(mem_read), .mem_rdata(mem_rdata),
        .cpu_stall(cpu_stall), .stall_cnt(stall_cnt)
    );

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_WAIT(4), .STAT_W(4)) dut_s (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(s_m0_gnt), .m0_rdata(s_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_gnt(s_m1_gnt), .m1_rdata(s_m1_rdata),
        .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_write(s_mem_write),
        .mem_read(s_mem_read), .mem_rdata(mem_rdata),
        .cpu_stall(s_cpu_stall), .stall_cnt(s_stall_cnt)
    );

    // Data memory: combinational read, write on the edge ending the grant.
    logic [31:0] mem [0:255];
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

    typedef struct {
        logic        g0, g1, wr, rd_en, stall, crd;
        logic [7:0]  addr;
        logic [31:0] wdata, rd;
        logic [15:0] cnt16;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // One cycle of stimulus plus its expected response.
    task automatic cyc(input logic r,
                       input logic q0, input logic w0, input logic [7:0] a0, input logic [31:0] d0,
                       input logic q1, input logic w1, input logic l1, input logic [7:0] a1,
                       input logic [31:0] d1,
                       input logic g0, input logic g1, input logic crd, input logic [31:0] rd);
        exp_t e;
        rst = r;
        m0_req = q0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = q1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
        e.g0 = g0; e.g1 = g1; e.crd = crd; e.rd = rd;
        e.addr = g0 ? a0 : (g1 ? a1 : 8'h0);
        e.wdata = g0 ? d0 : (g1 ? d1 : 32'h0);
        e.wr = (g0 & w0) | (g1 & w1);
        e.rd_en = (g0 & ~w0) | (g1 & ~w1);
        e.stall = q0 & ~g0 & ~r;
        e.cnt16 = 16'(stall_m);
        e.cnt4 = (stall_m > 15) ? 4'hF : 4'(stall_m);
        if (r) stall_m = 0;
        else if (e.stall) stall_m++;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("m0_gnt", 32'(m0_gnt), 32'(e.g0));
                chk("m1_gnt", 32'(m1_gnt), 32'(e.g1));
                chk("mem_write", 32'(mem_write), 32'(e.wr));
                chk("mem_read", 32'(mem_read), 32'(e.rd_en));
                chk("mem_addr", 32'(mem_addr), 32'(e.addr));
                chk("mem_wdata", mem_wdata, e.wdata);
                chk("cpu_stall", 32'(cpu_stall), 32'(e.stall));
                chk("stall_cnt", 32'(stall_cnt), 32'(e.cnt16));
                chk("stall_cnt_w4", 32'(s_stall_cnt), 32'(e.cnt4));
                if (e.crd) chk("rdata", e.g0 ? m0_rdata : m1_rdata, e.rd);
            end else if (m0_gnt || m1_gnt) begin
                chk("unexpected_gnt", 32'({m1_gnt, m0_gnt}), 32'h0);
            end
        end
    end

    initial begin : driver
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;
        @(posedge clk);
        #1;

        // Reset: requests present but nothing granted or written.
        cyc(1, 0,0,8'h00,32'h0,        0,0,0,8'h00,32'h0,  0,0, 0,32'h0);
        cyc(1, 1,1,8'h10,32'h1111,     1,1,0,8'h11,32'h2222, 0,0, 0,32'h0);

        // CPU alone: write then read back.
        cyc(0, 1,1,8'h10,32'hDEADBEEF, 0,0,0,8'h00,32'h0,  1,0, 0,32'h0);
        cyc(0, 1,1,8'h41,32'h12345678, 0,0,0,8'h00,32'h0,  1,0, 0,32'h0);
        cyc(0, 1,0,8'h10,32'h0,        0,0,0,8'h00,32'h0,  1,0, 1,32'hDEADBEEF);

        // Both request: CPU wins 4 cycles, debug forced through on the 5th.
        for (int i = 0; i < 4; i++)
            cyc(0, 1,0,8'h10,32'h0, 1,0,0,8'h10,32'h0, 1,0, 1,32'hDEADBEEF);
        cyc(0, 1,0,8'h10,32'h0, 1,0,0,8'h10,32'h0, 0,1, 1,32'hDEADBEEF);
        cyc(0, 1,0,8'h10,32'h0, 0,0,0,8'h00,32'h0, 1,0, 0,32'h0);

        // Debug alone: granted immediately; wait count stays clear so the CPU wins a tie.
        cyc(0, 0,0,8'h00,32'h0, 1,1,0,8'h30,32'h55, 0,1, 0,32'h0);
        cyc(0, 0,0,8'h00,32'h0, 1,0,0,8'h30,32'h0,  0,1, 1,32'h55);
        cyc(0, 1,0,8'h30,32'h0, 1,0,0,8'h30,32'h0,  1,0, 1,32'h55);
        cyc(0, 0,0,8'h00,32'h0, 0,0,0,8'h00,32'h0,  0,0, 0,32'h0);

        // Locked debug burst of 4 writes; lock drops on the last one.
        for (int i = 0; i < 4; i++)
            cyc(0, 1,0,8'h10,32'h0, 1,1,1,8'h20,32'h1, 1,0, 1,32'hDEADBEEF);
        for (int k = 0; k < 4; k++)
            cyc(0, 1,0,8'h10,32'h0, 1,1,(k != 3),8'(8'h20 + k),32'(k + 1), 0,1, 0,32'h0);
        cyc(0, 1,0,8'h23,32'h0, 0,0,0,8'h00,32'h0, 1,0, 1,32'h4);
        cyc(0, 0,0,8'h00,32'h0, 1,0,0,8'h20,32'h0, 0,1, 1,32'h1);

        // Reset in the 2nd cycle of a locked burst: write suppressed, FSM idle.
        for (int i = 0; i < 4; i++)
            cyc(0, 1,0,8'h41,32'h0, 1,1,1,8'h40,32'hAA, 1,0, 1,32'h12345678);
        cyc(0, 1,0,8'h41,32'h0, 1,1,1,8'h40,32'hAA, 0,1, 0,32'h0);
        cyc(1, 1,0,8'h41,32'h0, 1,1,1,8'h41,32'hBB, 0,0, 0,32'h0);
        cyc(0, 1,0,8'h41,32'h0, 1,1,1,8'h41,32'hBB, 1,0, 1,32'h12345678);
        cyc(0, 1,0,8'h40,32'h0, 0,0,0,8'h00,32'h0,  1,0, 1,32'hAA);

        // Stall saturation: 20 stalled cycles under a locked debug read burst.
        cyc(1, 0,0,8'h00,32'h0, 0,0,0,8'h00,32'h0, 0,0, 0,32'h0);
        for (int i = 0; i < 4; i++)
            cyc(0, 1,0,8'h10,32'h0, 1,0,1,8'h20,32'h0, 1,0, 1,32'hDEADBEEF);
        for (int k = 0; k < 20; k++)
            cyc(0, 1,0,8'h10,32'h0, 1,0,(k != 19),8'h20,32'h0, 0,1, 1,32'h1);
        cyc(0, 1,0,8'h10,32'h0, 0,0,0,8'h00,32'h0, 1,0, 1,32'hDEADBEEF);
        cyc(0, 0,0,8'h00,32'h0, 0,0,0,8'h00,32'h0, 0,0, 0,32'h0);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
